multicycle_control_unit: RTL and testbench

- FSM-based control unit for the multicycle RV32I core; replaces the single-cycle combinational decoder.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
- Drives datapath enables and a shared instruction/data memory through a req/ready handshake, with a timeout.
- Keeps the existing 4-bit ALUOp encoding and counts retired instructions.

---
 rtl/multicycle_control_unit.sv | 165 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// FSM control unit for the multicycle RV32I core: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory req/ready handshake with timeout, retired-instruction counter. Optional macro: ILLEGAL_TRAP_EN.
module multicycle_control_unit #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCJump,
  output logic               branch,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               bus_err,
  output logic [CNT_W-1:0]   instret
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               illegal_instr
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [2:0]    state, state_d;
  logic [CW-1:0] cnt;
  logic [6:0]    op_q;
  logic          run;
  logic          in_fetch, in_decode, in_exec, in_mem, in_wb;
  logic          to, ack, retire, legal_in;
  logic          is_load, is_store, is_br, is_jal, is_jalr, is_auipc, is_i;
  logic [3:0]    aop;

  // Class decode of the opcode captured in DECODE.
  always_comb begin
    aop      = 4'h0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_br    = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    is_auipc = 1'b0;
    is_i     = 1'b0;
    case (op_q)
      OP_LOAD:   begin aop = 4'b0000; is_load  = 1'b1; end
      OP_I:      begin aop = 4'b0001; is_i     = 1'b1; end
      OP_AUIPC:  begin aop = 4'b0010; is_auipc = 1'b1; end
      OP_STORE:  begin aop = 4'b0011; is_store = 1'b1; end
      OP_R:            aop = 4'b0100;
      OP_LUI:          aop = 4'b0101;
      OP_BRANCH: begin aop = 4'b0110; is_br    = 1'b1; end
      OP_JALR:   begin aop = 4'b0111; is_jalr  = 1'b1; end
      OP_JAL:    begin aop = 4'b1000; is_jal   = 1'b1; end
      default:         aop = 4'h0;
    endcase
  end

  always_comb begin
    legal_in = 1'b0;
    case (opcode)
      OP_LOAD, OP_I, OP_AUIPC, OP_STORE, OP_R,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: legal_in = 1'b1;
      default:                            legal_in = 1'b0;
    endcase
  end

  assign in_fetch  = (state == S_FETCH);
  assign in_decode = (state == S_DECODE);
  assign in_exec   = (state == S_EXEC);
  assign in_mem    = (state == S_MEM);
  assign in_wb     = (state == S_WB);

  // Timeout cycle: request withdrawn, so a late mem_ready here is ignored.
  assign to      = (in_fetch || in_mem) && (cnt == CW'(MEM_TIMEOUT));
  assign mem_req = run && (in_fetch || in_mem) && !to;
  assign ack     = mem_req && mem_ready;
  assign retire  = in_wb || (in_exec && is_br) || (in_mem && is_store && ack);

  always_comb begin
    state_d = state;
    case (state)
      S_FETCH:  if (to) state_d = S_FETCH;
                else if (ack) state_d = S_DECODE;
      S_DECODE: begin
        if (legal_in) state_d = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        else          state_d = S_TRAP;
`else
        else          state_d = S_FETCH;
`endif
      end
      S_EXEC:   if (is_br) state_d = S_FETCH;
                else if (is_load || is_store) state_d = S_MEM;
                else state_d = S_WB;
      S_MEM:    if (to) state_d = S_FETCH;
                else if (ack) state_d = is_load ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // run holds the request off for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      cnt     <= '0;
      op_q    <= '0;
      run     <= 1'b0;
      instret <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_d;
      if (in_decode) op_q <= opcode;
      if (state_d != state || to) cnt <= '0;
      else if (mem_req && !mem_ready) cnt <= cnt + 1'b1;
      if (retire) instret <= instret + 1'b1;
    end
  end

  assign IorD     = in_mem && mem_req;
  assign MemRead  = mem_req && (in_fetch || is_load);
  assign MemWrite = mem_req && in_mem && is_store;
  assign IRWrite  = in_fetch && ack;
  assign PCWrite  = in_fetch && ack;
  assign PCJump   = in_exec && (is_jal || is_jalr);
  assign branch   = in_exec && is_br;
  assign ALUSrc   = in_exec && (is_load || is_i || is_store || is_jalr);
  assign ALUOp    = (in_exec || (in_mem && !to)) ? ALUOP_W'(aop) : '0;
  assign MemToReg = in_wb && (is_load || is_auipc);
  assign RegWrite = in_wb;
  assign bus_err  = to;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: instruction-level reference model expands each
// instruction into its expected per-cycle output vectors; a negedge monitor pops and compares.
module tb_multicycle_control_unit;
  localparam int TO = 16;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] OPI    = 7'b0010011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCJump, branch, ALUSrc;
  logic [3:0]  ALUOp;
  logic        MemToReg, RegWrite, bus_err;
  logic [31:0] instret;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_instr;
`endif

  multicycle_control_unit #(.ALUOP_W(4), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCJump(PCJump), .branch(branch),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .bus_err(bus_err), .instret(instret)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic req, iord, mrd, mwr, irw, pcw, pcj, br, asrc;
    logic [3:0] aop;
    logic m2r, rw, berr, ill;
    logic [31:0] ir;
  } vec_t;

  vec_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_ir = '0;

  always @(negedge clk) begin
    vec_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '0;
      a.req = mem_req; a.iord = IorD; a.mrd = MemRead; a.mwr = MemWrite;
      a.irw = IRWrite; a.pcw = PCWrite; a.pcj = PCJump; a.br = branch;
      a.asrc = ALUSrc; a.aop = ALUOp; a.m2r = MemToReg; a.rw = RegWrite;
      a.berr = bus_err; a.ir = instret;
`ifdef ILLEGAL_TRAP_EN
      a.ill = illegal_instr;
`endif
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle_outputs @%0t: got %h want %h", $time, a, e);
      end
    end
  end

  function automatic vec_t z();
    vec_t v = '0;
    v.ir = exp_ir;
    return v;
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Spec table: opcode -> legality, ALUOp, immediate operand.
  function automatic void info(input logic [6:0] op, output bit legal,
                               output logic [3:0] alu, output bit asrc);
    legal = 1'b1; asrc = 1'b0; alu = 4'h0;
    case (op)
      LOAD:    begin alu = 4'b0000; asrc = 1'b1; end
      OPI:     begin alu = 4'b0001; asrc = 1'b1; end
      AUIPC:         alu = 4'b0010;
      STORE:   begin alu = 4'b0011; asrc = 1'b1; end
      RTYPE:         alu = 4'b0100;
      LUI:           alu = 4'b0101;
      BRANCH:        alu = 4'b0110;
      JALR:    begin alu = 4'b0111; asrc = 1'b1; end
      JAL:           alu = 4'b1000;
      default:       legal = 1'b0;
    endcase
  endfunction

  task automatic cyc(input vec_t e, input logic rdy, input logic [6:0] op, input logic r);
    @(posedge clk);
    #1;
    rst_n = r; mem_ready = rdy; opcode = op;
    sb.push_back(e);
  endtask

  task automatic reset_seq();
    exp_ir = '0;
    cyc(z(), rbit(), rop(), 1'b0);
    cyc(z(), rbit(), rop(), 1'b0);
    cyc(z(), rbit(), rop(), 1'b1);
  endtask

  // A memory access that waits lat cycles; lat >= TO ends in a timeout pulse.
  task automatic mem_wait(input vec_t busy, input vec_t done, input int lat, output bit ok);
    vec_t e;
    if (lat >= TO) begin
      repeat (TO) cyc(busy, 1'b0, rop(), 1'b1);
      e = z(); e.berr = 1'b1;
      cyc(e, rbit(), rop(), 1'b1);
      ok = 1'b0;
    end else begin
      repeat (lat) cyc(busy, 1'b0, rop(), 1'b1);
      cyc(done, 1'b1, rop(), 1'b1);
      ok = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input int f, input int m, input bit abort);
    vec_t b, d, e;
    bit ok, legal, asrc;
    logic [3:0] alu;
    b = z(); b.req = 1'b1; b.mrd = 1'b1;
    d = b; d.irw = 1'b1; d.pcw = 1'b1;
    mem_wait(b, d, f, ok);
    if (!ok) return;
    cyc(z(), rbit(), op, 1'b1);
    info(op, legal, alu, asrc);
    if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
      repeat (3) begin e = z(); e.ill = 1'b1; cyc(e, rbit(), rop(), 1'b1); end
      reset_seq();
`endif
      return;
    end
    e = z(); e.aop = alu; e.asrc = asrc;
    e.br = (op == BRANCH); e.pcj = (op == JAL || op == JALR);
    cyc(e, rbit(), rop(), 1'b1);
    if (op == BRANCH) begin exp_ir++; return; end
    if (op == LOAD || op == STORE) begin
      b = z(); b.req = 1'b1; b.iord = 1'b1; b.aop = alu;
      b.mrd = (op == LOAD); b.mwr = (op == STORE);
      if (abort) begin
        repeat (m) cyc(b, 1'b0, rop(), 1'b1);
        reset_seq();
        return;
      end
      mem_wait(b, b, m, ok);
      if (!ok) return;
      if (op == STORE) begin exp_ir++; return; end
    end
    e = z(); e.rw = 1'b1; e.m2r = (op == LOAD || op == AUIPC);
    cyc(e, rbit(), rop(), 1'b1);
    exp_ir++;
  endtask

  function automatic int rlat();
    int r = int'($urandom_range(0, 19));
    if (r < 14) return r % 4;
    if (r < 17) return TO - 1;
    return TO;
  endfunction

  function automatic logic [6:0] pick();
    int k = int'($urandom_range(0, 9));
    case (k)
      0: return LOAD;  1: return OPI;    2: return AUIPC;
      3: return STORE; 4: return RTYPE;  5: return LUI;
      6: return BRANCH; 7: return JALR;  8: return JAL;
      default: return rop();
    endcase
  endfunction

  initial begin
    int guard;
    reset_seq();
    run_instr(RTYPE, 0, 0, 1'b0);
    run_instr(LOAD, 0, 3, 1'b0);
    run_instr(STORE, 0, 0, 1'b0);
    run_instr(BRANCH, 0, 0, 1'b0);
    run_instr(JAL, 1, 0, 1'b0);
    run_instr(RTYPE, TO, 0, 1'b0);
    run_instr(7'b1111111, 0, 0, 1'b0);
    run_instr(LOAD, TO - 1, TO - 1, 1'b0);
    run_instr(STORE, 0, TO, 1'b0);
    run_instr(AUIPC, 2, 0, 1'b0);
    run_instr(LOAD, 0, 2, 1'b1);
    run_instr(LUI, 0, 0, 1'b0);
    repeat (150) run_instr(pick(), rlat(), rlat(), 1'b0);
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    n_cmp++;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
